// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - MIPS fetch-stage program counter with prioritised next-PC select,
// misaligned-target fault state and a circular history of retired PC values.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(4),
  parameter int               INC        = 4,
  parameter int               HIST_DEPTH = 4,
  localparam int              IW         = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             fault,
  input  logic [IW-1:0]    hist_idx,
  output logic [WIDTH-1:0] hist_pc,
  output logic [IW:0]      hist_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  localparam logic [IW:0] CNT_MAX = (IW+1)'(HIST_DEPTH);

  state_t           state;
  logic [WIDTH-1:0] run_tgt;
  logic             run_misalign;
  logic             push;
  logic [IW-1:0]    wp;
  logic [WIDTH-1:0] hist_mem [HIST_DEPTH];

  // Next PC while running; eret/redirect targets are the only ones alignment-checked.
  always_comb begin
    run_tgt      = pc + WIDTH'(INC);
    run_misalign = 1'b0;
    if (exc) begin
      run_tgt = EXC_VEC;
    end else if (eret) begin
      run_tgt      = epc_in;
      run_misalign = (epc_in[1:0] != 2'b00);
    end else if (redirect) begin
      run_tgt      = redirect_pc;
      run_misalign = (redirect_pc[1:0] != 2'b00);
    end else if (stall) begin
      run_tgt = pc;
    end
  end

  assign push = (state == RUN) && !run_misalign && (run_tgt != pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      fault    <= 1'b0;
      wp       <= '0;
      hist_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (run_misalign) begin
            state    <= FAULT;
            fault    <= 1'b1;
            pc_valid <= 1'b0;
          end else begin
            pc <= run_tgt;
          end
        end
        FAULT: begin
          if (exc) begin
            state    <= RUN;
            pc       <= EXC_VEC;
            fault    <= 1'b0;
            pc_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
      if (push) begin
        wp <= wp + IW'(1);
        if (hist_cnt != CNT_MAX) hist_cnt <= hist_cnt + 1'b1;
      end
    end
  end

  // History storage carries no reset; stale entries are masked by hist_cnt.
  always_ff @(posedge clk) begin
    if (push) hist_mem[wp] <= pc;
  end

  assign hist_pc = hist_mem[wp - IW'(1) - hist_idx];

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed table-driven bench for pc_unit (32-bit and 8-bit instances).
module tb_pc_unit;

  typedef struct {
    logic        st, ex, er, rd;
    logic [31:0] epc, rpc;
    logic [31:0] pc;
    logic        vld, flt;
    logic [31:0] cnt;
    logic        hchk;
    logic [31:0] h0;
  } vec_t;

  logic        clk = 0;
  logic        rst, stall, exc, eret, redirect;
  logic [31:0] epc_in, redirect_pc, pc, hist_pc;
  logic        pc_valid, fault;
  logic [1:0]  hist_idx;
  logic [2:0]  hist_cnt;

  logic        rst8, stall8, exc8, eret8, redirect8;
  logic [7:0]  epc8, rpc8, pc8, hist_pc8;
  logic        pc_valid8, fault8;
  logic [1:0]  hist_idx8;
  logic [2:0]  hist_cnt8;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc(exc), .eret(eret), .epc_in(epc_in),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc), .pc_valid(pc_valid),
    .fault(fault), .hist_idx(hist_idx), .hist_pc(hist_pc), .hist_cnt(hist_cnt)
  );

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h00), .EXC_VEC(8'h04)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .exc(exc8), .eret(eret8), .epc_in(epc8),
    .redirect(redirect8), .redirect_pc(rpc8), .pc(pc8), .pc_valid(pc_valid8),
    .fault(fault8), .hist_idx(hist_idx8), .hist_pc(hist_pc8), .hist_cnt(hist_cnt8)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, ex, er, rd, input logic [31:0] epc, rpc, epcv,
                              input logic vld, flt, input int cnt, input logic hchk,
                              input logic [31:0] h0);
    vec_t v;
    v.st = st; v.ex = ex; v.er = er; v.rd = rd; v.epc = epc; v.rpc = rpc; v.pc = epcv;
    v.vld = vld; v.flt = flt; v.cnt = cnt; v.hchk = hchk; v.h0 = h0;
    return v;
  endfunction

  initial begin
    logic [31:0] hexp [4];
    hexp[0] = 32'h14; hexp[1] = 32'h10; hexp[2] = 32'h0C; hexp[3] = 32'h08;

    rst = 1; stall = 0; exc = 0; eret = 0; redirect = 0; epc_in = 0; redirect_pc = 0;
    hist_idx = 0;
    rst8 = 1; stall8 = 0; exc8 = 0; eret8 = 0; redirect8 = 0; epc8 = 0; rpc8 = 0;
    hist_idx8 = 0;

    //        st ex er rd  epc       rpc       pc        v  f  cnt hchk h0
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   32'h100, 32'h0,   1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h4,   1, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h8,   1, 0, 2, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'hC,   1, 0, 3, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h10,  1, 0, 4, 1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h14,  1, 0, 4, 1, 32'h10));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h18,  1, 0, 4, 1, 32'h14));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h18,  1, 0, 4, 1, 32'h14));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h18,  1, 0, 4, 1, 32'h14));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h18,  1, 0, 4, 1, 32'h14));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h1C,  1, 0, 4, 1, 32'h18));
    tbl.push_back(mk(1, 1, 1, 1, 32'h200, 32'h300, 32'h4,   1, 0, 4, 1, 32'h1C));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   32'h100, 32'h100, 1, 0, 4, 1, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 32'h80,  32'h0,   32'h80,  1, 0, 4, 1, 32'h100));
    tbl.push_back(mk(0, 0, 1, 1, 32'h90,  32'h103, 32'h90,  1, 0, 4, 1, 32'h80));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   32'h102, 32'h90,  0, 1, 4, 1, 32'h80));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   32'h200, 32'h90,  0, 1, 4, 1, 32'h80));
    tbl.push_back(mk(0, 0, 1, 0, 32'h300, 32'h0,   32'h90,  0, 1, 4, 1, 32'h80));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h90,  0, 1, 4, 1, 32'h80));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,   32'h4,   1, 0, 4, 1, 32'h80));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h8,   1, 0, 4, 1, 32'h4));
    tbl.push_back(mk(0, 0, 1, 0, 32'h41,  32'h0,   32'h8,   0, 1, 4, 1, 32'h4));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,   32'h0,   32'h4,   1, 0, 4, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   32'h3C,  32'h3C,  1, 0, 4, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   32'h0,   32'h40,  1, 0, 4, 1, 32'h3C));

    repeat (2) step();
    chk("reset pc", pc, 32'h0);
    chk("reset pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("reset fault", {31'b0, fault}, 32'h0);
    chk("reset hist_cnt", {29'b0, hist_cnt}, 32'h0);
    rst = 0;

    foreach (tbl[i]) begin
      stall = tbl[i].st; exc = tbl[i].ex; eret = tbl[i].er; redirect = tbl[i].rd;
      epc_in = tbl[i].epc; redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("row%0d pc_valid", i), {31'b0, pc_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("row%0d fault", i), {31'b0, fault}, {31'b0, tbl[i].flt});
      chk($sformatf("row%0d hist_cnt", i), {29'b0, hist_cnt}, tbl[i].cnt);
      if (tbl[i].hchk) chk($sformatf("row%0d hist0", i), hist_pc, tbl[i].h0);
      if (i == 6) begin
        for (int k = 0; k < 4; k++) begin
          hist_idx = 2'(k);
          #1;
          chk($sformatf("hist idx%0d", k), hist_pc, hexp[k]);
        end
        hist_idx = 0;
      end
    end
    stall = 0; exc = 0; eret = 0; redirect = 0;

    // asynchronous reset mid-run, released before the next edge
    rst = 1;
    #2;
    chk("async rst pc", pc, 32'h0);
    chk("async rst pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("async rst hist_cnt", {29'b0, hist_cnt}, 32'h0);
    rst = 0;
    step();
    chk("post rst boot pc", pc, 32'h0);
    chk("post rst boot pc_valid", {31'b0, pc_valid}, 32'h1);
    step();
    chk("post rst seq1", pc, 32'h4);
    chk("post rst hist_cnt", {29'b0, hist_cnt}, 32'h1);
    step();
    chk("post rst seq2", pc, 32'h8);

    // 8-bit instance: sequential wrap from 0xFC
    rst8 = 0;
    step();
    chk("w8 boot pc", {24'b0, pc8}, 32'h0);
    redirect8 = 1; rpc8 = 8'hFC;
    step();
    chk("w8 redirect pc", {24'b0, pc8}, 32'hFC);
    redirect8 = 0;
    step();
    chk("w8 wrap pc", {24'b0, pc8}, 32'h0);
    chk("w8 hist_cnt", {29'b0, hist_cnt8}, 32'h2);
    chk("w8 hist0", {24'b0, hist_pc8}, 32'hFC);
    hist_idx8 = 1;
    #1;
    chk("w8 hist1", {24'b0, hist_pc8}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
